// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg
// Shared types for the data-memory arbiter: grant FSM states and the
// owner tag carried alongside an outstanding read.
package dmem_arb_pkg;

    typedef enum logic {
        ARB = 1'b0,
        DMA = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the three sides of the data-memory arbiter.
//   core side : c_req, c_we, c_addr, c_wdata  -> c_gnt, c_rvalid, c_rdata, core_stall
//   DMA side  : d_req, d_we, d_last, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//   memory    : m_en, m_we, m_addr, m_wdata  <- m_rdata (valid the cycle after m_en)
// slave  : used by the arbiter itself
// master : used by whatever drives the requests and models the memory
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_last;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    logic              core_stall;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_last, d_addr, d_wdata,
        input  m_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata,
        output core_stall
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_last, d_addr, d_wdata,
        output m_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        input  core_stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between the pipeline M stage (core)
// and a loader/DMA port. Grants are combinational from the grant FSM, the
// burst-beat counter, the starvation counter and the current requests; the
// memory strobe follows the grant in the same cycle. Read data returns one
// cycle after the accepted beat and is routed to the port that issued it.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : dmem_arbiter_if.slave (core, DMA and memory sides, core_stall)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     bus
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    arb_state_t          r_state;
    logic [BW-1:0]       r_beat_cnt;
    logic [SW-1:0]       r_starve_cnt;
    logic                r_rd_pend;
    owner_t              r_owner;
    logic [DATA_W-1:0]   r_c_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    arb_state_t          w_state_nxt;
    logic [BW-1:0]       w_beat_nxt;
    logic [BW-1:0]       w_beat_inc;
    logic [SW-1:0]       w_starve_nxt;
    logic                w_starved;
    logic                w_c_gnt;
    logic                w_d_gnt;
    logic                w_c_resp;
    logic                w_d_resp;

    assign w_starved  = (r_starve_cnt == SW'(STARVE_LIM));
    assign w_beat_inc = r_beat_cnt + BW'(1);

    // Grant decision from ownership state and current requests
    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        case (r_state)
            ARB: begin
                // Core wins ties unless the DMA has waited STARVE_LIM cycles
                if (bus.d_req && (!bus.c_req || w_starved)) begin
                    w_d_gnt = 1'b1;
                end else if (bus.c_req) begin
                    w_c_gnt = 1'b1;
                end else begin
                    w_d_gnt = 1'b0;
                end
            end
            DMA: begin
                // Dropping d_req releases ownership immediately, so the core
                // can use the port in the very same cycle
                w_d_gnt = bus.d_req;
                w_c_gnt = bus.c_req && !bus.d_req;
            end
            default: begin
                w_c_gnt = 1'b0;
                w_d_gnt = 1'b0;
            end
        endcase
    end

    // Next ownership state and burst-beat count
    always_comb begin
        w_state_nxt = ARB;
        w_beat_nxt  = {BW{1'b0}};
        case (r_state)
            ARB: begin
                // A single-beat ownership (d_last on the first beat, or a
                // burst cap of one) never enters DMA
                if (w_d_gnt && !bus.d_last && (MAX_BURST != 1)) begin
                    w_state_nxt = DMA;
                    w_beat_nxt  = BW'(1);
                end else begin
                    w_state_nxt = ARB;
                    w_beat_nxt  = {BW{1'b0}};
                end
            end
            DMA: begin
                if (w_d_gnt && !bus.d_last && (w_beat_inc != BW'(MAX_BURST))) begin
                    w_state_nxt = DMA;
                    w_beat_nxt  = w_beat_inc;
                end else begin
                    w_state_nxt = ARB;
                    w_beat_nxt  = {BW{1'b0}};
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_beat_nxt  = {BW{1'b0}};
            end
        endcase
    end

    // Starvation counter: counts waiting DMA cycles, saturating
    always_comb begin
        if (w_d_gnt) begin
            w_starve_nxt = {SW{1'b0}};
        end else if (bus.d_req && !w_starved) begin
            w_starve_nxt = r_starve_cnt + SW'(1);
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // Ownership, counters and read-response bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB;
            r_beat_cnt   <= {BW{1'b0}};
            r_starve_cnt <= {SW{1'b0}};
            r_rd_pend    <= 1'b0;
            r_owner      <= OWN_CORE;
            r_c_rdata    <= {DATA_W{1'b0}};
            r_d_rdata    <= {DATA_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_beat_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_rd_pend    <= (w_c_gnt && !bus.c_we) || (w_d_gnt && !bus.d_we);
            r_owner      <= w_d_gnt ? OWN_DMA : OWN_CORE;
            // Capture the returning word so each port keeps its last read
            if (w_c_resp) begin
                r_c_rdata <= bus.m_rdata;
            end else begin
                r_c_rdata <= r_c_rdata;
            end
            if (w_d_resp) begin
                r_d_rdata <= bus.m_rdata;
            end else begin
                r_d_rdata <= r_d_rdata;
            end
        end
    end

    assign w_c_resp = r_rd_pend && (r_owner == OWN_CORE);
    assign w_d_resp = r_rd_pend && (r_owner == OWN_DMA);

    assign bus.c_gnt      = w_c_gnt;
    assign bus.d_gnt      = w_d_gnt;
    assign bus.core_stall = bus.c_req && !w_c_gnt;

    // The memory only sees data this cycle, so its word is forwarded directly
    assign bus.c_rvalid = w_c_resp;
    assign bus.d_rvalid = w_d_resp;
    assign bus.c_rdata  = w_c_resp ? bus.m_rdata : r_c_rdata;
    assign bus.d_rdata  = w_d_resp ? bus.m_rdata : r_d_rdata;

    // Memory port follows the granted requester; quiet when idle
    assign bus.m_en    = w_c_gnt || w_d_gnt;
    assign bus.m_we    = w_d_gnt ? bus.d_we    : (w_c_gnt ? bus.c_we    : 1'b0);
    assign bus.m_addr  = w_d_gnt ? bus.d_addr  : (w_c_gnt ? bus.c_addr  : {ADDR_W{1'b0}});
    assign bus.m_wdata = w_d_gnt ? bus.d_wdata : (w_c_gnt ? bus.c_wdata : {DATA_W{1'b0}});

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the pipeline's memory stage (core port) and a loader/DMA port that fills or dumps data memory while the core runs. It sits between the M-stage address/write-data/mem-write signals and `data_mem`. It owns a small grant state machine, a burst-beat counter, a starvation counter and a registered read-response path. It drives `core_stall` to the hazard unit so the pipeline freezes while the core is locked out.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_BURST`, 4, maximum accepted DMA beats per ownership (≥1)
- `STARVE_LIM`, 8, cycles a waiting DMA request tolerates before overriding the core (≥1)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-high
- `c_req`, `c_we`  in  1  core request, write enable
- `c_addr`  in  ADDR_W;  `c_wdata`  in  DATA_W
- `c_gnt`  out  1  core beat accepted this cycle
- `c_rvalid`  out  1;  `c_rdata`  out  DATA_W  core read response
- `d_req`, `d_we`, `d_last`  in  1  DMA request, write enable, final beat of burst
- `d_addr`  in  ADDR_W;  `d_wdata`  in  DATA_W
- `d_gnt`  out  1;  `d_rvalid`  out  1;  `d_rdata`  out  DATA_W
- `m_en`, `m_we`  out  1  memory access strobe, write enable
- `m_addr`  out  ADDR_W;  `m_wdata`  out  DATA_W;  `m_rdata`  in  DATA_W  (read data valid the cycle after `m_en`)
- `core_stall`  out  1  `c_req & ~c_gnt`

## Operation
- A beat is accepted in any cycle where `req & gnt`. Grants are combinational from state, counters and current requests.
- `m_*` is driven from the granted requester. `m_en` = any grant. `m_we` = granted `we`. When nothing is granted, `m_en`=0 and addr/wdata are don't-care.
- FSM states: `ARB`, `DMA`.
- In `ARB`:
  - If `d_req && (!c_req || starve_cnt==STARVE_LIM)`, grant DMA. Go to `DMA` unless `d_last` or `MAX_BURST==1`.
  - Otherwise, if `c_req`, grant the core.
- In `DMA`:
  - `d_gnt = d_req`, `c_gnt = 0`.
  - Return to `ARB` after an accepted beat with `d_last`, or when that beat is the `MAX_BURST`th.
  - If `d_req` is low in `DMA`, ownership is released the same cycle: go to `ARB`, and the core is granted that cycle if `c_req`.
- `beat_cnt`: set to 1 on the entering grant, +1 per accepted DMA beat, cleared on return to `ARB`.
- `starve_cnt`: +1 per cycle with `d_req & ~d_gnt`, saturates at `STARVE_LIM`, cleared on any DMA grant.
- Read response: on an accepted read beat, register `owner` and `rd_pend`. Next cycle, the owner's `rvalid`=1 and its `rdata`=`m_rdata`. The other port's `rdata` holds its last value.
- Writes produce no response.

## Timing
- Grant and memory strobe: 0 cycles after request (same cycle). Read data: 1 cycle after the accepted beat.
- Back-to-back beats are allowed every cycle. Responses pipeline one per cycle, in order.
- Reset values: state `ARB`; `beat_cnt`, `starve_cnt`, `rd_pend` = 0; `c_rvalid`, `d_rvalid` = 0; `c_rdata`, `d_rdata` = 0. Combinational outputs are 0 when no request is present.
- Reset mid-burst or with a read pending: the burst is aborted and no response is produced after reset deasserts.
- Simultaneous `c_req` and `d_req` in `ARB` with `starve_cnt < STARVE_LIM`: the core wins.
- `d_last` on the first beat: single-beat ownership, no `DMA` state entry.
- Overflow: `beat_cnt` never exceeds `MAX_BURST`, and `starve_cnt` never exceeds `STARVE_LIM`.

## Structure
- `dmem_arb_pkg` contains:
  - `typedef enum logic {ARB, DMA} arb_state_t`
  - `typedef enum logic {OWN_CORE, OWN_DMA} owner_t`
- Counter widths are derived via `$clog2(MAX_BURST+1)` and `$clog2(STARVE_LIM+1)` inside the module.
- Single flat module; no sub-module is warranted.

## Test plan
- **Core-only reads:** `c_req` with addrs 0x10, 0x14 on consecutive cycles → `c_gnt`=1 both cycles; `c_rvalid` on cycles +1 and +2 carries mem[0x10] and mem[0x14]; `core_stall`=0 throughout.
- **Contention:** `c_req` and `d_req` both held continuously → core granted 8 cycles, then DMA granted on cycle 9 (`starve_cnt`=8); `core_stall`=1 during the DMA ownership.
- **Burst cap:** DMA 6-beat write burst, `d_last` on beat 6, core idle → after 4 accepted beats, one `ARB` cycle, then a new ownership accepts beats 5–6 and returns to `ARB`.
- **Early release:** DMA burst with `d_req` dropped after beat 2 while `c_req`=1 → `c_gnt`=1 that same cycle; state is `ARB`.
- **Response routing:** DMA read at 0x20 immediately followed by a core read at 0x24 → `d_rvalid` with mem[0x20], then `c_rvalid` with mem[0x24]; no cross-port `rvalid`.
- **Reset mid-burst:** `rst` asserted on beat 2 of a DMA read burst → all `rvalid` = 0, state `ARB`, counters 0; the next core request is granted immediately.
